// File: rtl/action_engine_pipe.sv
// Two-stage action engine: stage 1 captures the action, PHV and a stateful memory word;
// stage 2 executes the action, drives phv_out and performs the stateful memory write.
module action_engine_pipe #(
    parameter int unsigned STAGE      = 0,
    parameter int unsigned CONT_W     = 32,
    parameter int unsigned NUM_CONT   = 8,
    parameter int unsigned IDX_W      = 3,
    parameter int unsigned IMM_W      = 16,
    parameter int unsigned MEM_DEPTH  = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned MD_W       = 256,
    parameter int unsigned PHV_LEN    = NUM_CONT*CONT_W+MD_W,
    parameter int unsigned ACTION_LEN = 4+2*IDX_W+IMM_W
) (
    input  logic                  axis_clk,
    input  logic                  aresetn,
    input  logic [ACTION_LEN-1:0] action_in,
    input  logic                  action_in_valid,
    input  logic [PHV_LEN-1:0]    phv_in,
    output logic                  ready_out,
    output logic [PHV_LEN-1:0]    phv_out,
    output logic                  phv_out_valid,
    input  logic                  ready_in
);

    typedef enum logic [3:0] {
        OP_NOP      = 4'h0,
        OP_ADD      = 4'h1,
        OP_SUB      = 4'h2,
        OP_ADDI     = 4'h3,
        OP_SUBI     = 4'h4,
        OP_SET      = 4'h5,
        OP_STORE    = 4'h6,
        OP_LOAD     = 4'h7,
        OP_LOADD    = 4'h8,
        OP_REDIRECT = 4'hC,
        OP_DISCARD  = 4'hD
    } op_t;

    logic                en;

    logic [3:0]          in_op;
    logic [IDX_W-1:0]    in_dst;
    logic [IDX_W-1:0]    in_src1;
    logic [IMM_W-1:0]    in_imm;
    logic [ADDR_W-1:0]   rd_addr;

    logic                s1_valid;
    op_t                 s1_op;
    logic [IDX_W-1:0]    s1_dst;
    logic [IDX_W-1:0]    s1_src1;
    logic [IMM_W-1:0]    s1_imm;
    logic [PHV_LEN-1:0]  s1_phv;
    logic [CONT_W-1:0]   s1_mem;

    logic [CONT_W-1:0]   mem [MEM_DEPTH];

    logic [IDX_W-1:0]    s1_src2;
    logic [ADDR_W-1:0]   wr_addr;
    logic [PHV_LEN-1:0]  next_phv;
    logic [CONT_W-1:0]   opa;
    logic [CONT_W-1:0]   opb;
    logic [CONT_W-1:0]   res;
    logic [CONT_W-1:0]   imm_ext;
    logic                has_dst;
    logic                dst_ok;
    logic                src1_ok;
    logic                src2_ok;
    logic                wr_req;
    logic [CONT_W-1:0]   wr_data;
    logic                mem_we;
    logic                fwd;

    assign en        = !phv_out_valid || ready_in;
    assign ready_out = en;

    assign in_op   = action_in[ACTION_LEN-1 -: 4];
    assign in_dst  = action_in[ACTION_LEN-5 -: IDX_W];
    assign in_src1 = action_in[ACTION_LEN-5-IDX_W -: IDX_W];
    assign in_imm  = action_in[IMM_W-1:0];
    assign rd_addr = in_imm[ADDR_W-1:0];

    assign s1_src2 = s1_imm[IDX_W-1:0];
    assign wr_addr = s1_imm[ADDR_W-1:0];
    assign mem_we  = en && s1_valid && wr_req;
    // The action leaving stage 2 may write the word stage 1 is reading on this edge.
    assign fwd     = mem_we && (wr_addr == rd_addr);

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_NOP;
            s1_dst   <= '0;
            s1_src1  <= '0;
            s1_imm   <= '0;
            s1_phv   <= '0;
            s1_mem   <= '0;
        end else if (en) begin
            s1_valid <= action_in_valid;
            s1_op    <= op_t'(in_op);
            s1_dst   <= in_dst;
            s1_src1  <= in_src1;
            s1_imm   <= in_imm;
            s1_phv   <= phv_in;
            s1_mem   <= fwd ? wr_data : mem[rd_addr];
        end
    end

    always_comb begin
        next_phv = s1_phv;
        opa      = '0;
        opb      = '0;
        res      = '0;
        has_dst  = 1'b0;
        wr_req   = 1'b0;
        wr_data  = '0;
        imm_ext  = CONT_W'(s1_imm);
        dst_ok   = 32'(s1_dst) < NUM_CONT;
        src1_ok  = 32'(s1_src1) < NUM_CONT;
        src2_ok  = 32'(s1_src2) < NUM_CONT;

        for (int unsigned k = 0; k < NUM_CONT; k++) begin
            if (IDX_W'(k) == s1_src1) opa = s1_phv[PHV_LEN-1-k*CONT_W -: CONT_W];
            if (IDX_W'(k) == s1_src2) opb = s1_phv[PHV_LEN-1-k*CONT_W -: CONT_W];
        end

        case (s1_op)
            OP_ADD: if (dst_ok && src1_ok && src2_ok) begin
                has_dst = 1'b1;
                res     = opa + opb;
            end
            OP_SUB: if (dst_ok && src1_ok && src2_ok) begin
                has_dst = 1'b1;
                res     = opa - opb;
            end
            OP_ADDI: if (dst_ok && src1_ok) begin
                has_dst = 1'b1;
                res     = opa + imm_ext;
            end
            OP_SUBI: if (dst_ok && src1_ok) begin
                has_dst = 1'b1;
                res     = opa - imm_ext;
            end
            OP_SET: if (dst_ok) begin
                has_dst = 1'b1;
                res     = imm_ext;
            end
            OP_STORE: if (src1_ok) begin
                wr_req  = 1'b1;
                wr_data = opa;
            end
            OP_LOAD: if (dst_ok) begin
                has_dst = 1'b1;
                res     = s1_mem;
            end
            OP_LOADD: if (dst_ok) begin
                has_dst = 1'b1;
                res     = s1_mem + CONT_W'(1);
                wr_req  = 1'b1;
                wr_data = s1_mem + CONT_W'(1);
            end
            OP_REDIRECT: next_phv[8:1] = s1_imm[7:0];
            OP_DISCARD:  next_phv[0]   = 1'b1;
            default: ;
        endcase

        if (has_dst) begin
            for (int unsigned k = 0; k < NUM_CONT; k++) begin
                if (IDX_W'(k) == s1_dst) next_phv[PHV_LEN-1-k*CONT_W -: CONT_W] = res;
            end
        end
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            phv_out       <= '0;
            phv_out_valid <= 1'b0;
            for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i[ADDR_W-1:0]] <= '0;
        end else if (en) begin
            phv_out_valid <= s1_valid;
            if (s1_valid) phv_out <= next_phv;
            if (mem_we) mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_action_engine_pipe.sv
// Randomised and directed bench for action_engine_pipe against an in-order
// sequential model of action semantics plus an enabled-edge latency queue.
module tb_action_engine_pipe;

    localparam int CW  = 32;
    localparam int NC  = 8;
    localparam int IW  = 4;
    localparam int MW  = 16;
    localparam int DEP = 32;
    localparam int PL  = NC*CW+MW;
    localparam int AL  = 4+2*IW+16;

    logic          axis_clk = 1'b0;
    logic          aresetn;
    logic [AL-1:0] action_in;
    logic          action_in_valid;
    logic [PL-1:0] phv_in;
    logic          ready_out;
    logic [PL-1:0] phv_out;
    logic          phv_out_valid;
    logic          ready_in;

    int checks = 0;
    int errors = 0;

    logic [CW-1:0] mm [DEP];
    logic [PL-1:0] q_phv [$];
    int            q_age [$];

    action_engine_pipe #(
        .STAGE(0), .CONT_W(CW), .NUM_CONT(NC), .IDX_W(IW), .IMM_W(16),
        .MEM_DEPTH(DEP), .ADDR_W(5), .MD_W(MW)
    ) dut (
        .axis_clk(axis_clk), .aresetn(aresetn), .action_in(action_in),
        .action_in_valid(action_in_valid), .phv_in(phv_in), .ready_out(ready_out),
        .phv_out(phv_out), .phv_out_valid(phv_out_valid), .ready_in(ready_in)
    );

    always #5 axis_clk = ~axis_clk;

    function automatic logic [CW-1:0] getc(input logic [PL-1:0] p, input int k);
        return p[PL-1-k*CW -: CW];
    endfunction

    function automatic logic [PL-1:0] putc(input logic [PL-1:0] p, input int k, input logic [CW-1:0] v);
        p[PL-1-k*CW -: CW] = v;
        return p;
    endfunction

    function automatic logic [AL-1:0] act(input int op, input int dst, input int src1, input logic [15:0] imm);
        return {4'(op), 4'(dst), 4'(src1), imm};
    endfunction

    function automatic logic [PL-1:0] rand_phv();
        logic [PL-1:0] p = '0;
        for (int i = 0; i < 9; i++) p = {p[PL-33:0], 32'($urandom)};
        return p;
    endfunction

    // Sequential semantics of one action; memory effects applied in program order.
    function automatic logic [PL-1:0] model(input logic [AL-1:0] a, input logic [PL-1:0] p);
        int op, dst, s1, s2, addr;
        logic [15:0] imm;
        logic [PL-1:0] o;
        op   = int'(a[AL-1 -: 4]);
        dst  = int'(a[AL-5 -: 4]);
        s1   = int'(a[AL-9 -: 4]);
        imm  = a[15:0];
        s2   = int'(imm[3:0]);
        addr = int'(imm[4:0]);
        o    = p;
        case (op)
            1: if (dst < NC && s1 < NC && s2 < NC) o = putc(o, dst, getc(p, s1) + getc(p, s2));
            2: if (dst < NC && s1 < NC && s2 < NC) o = putc(o, dst, getc(p, s1) - getc(p, s2));
            3: if (dst < NC && s1 < NC) o = putc(o, dst, getc(p, s1) + {16'h0, imm});
            4: if (dst < NC && s1 < NC) o = putc(o, dst, getc(p, s1) - {16'h0, imm});
            5: if (dst < NC) o = putc(o, dst, {16'h0, imm});
            6: if (s1 < NC) mm[addr] = getc(p, s1);
            7: if (dst < NC) o = putc(o, dst, mm[addr]);
            8: if (dst < NC) begin
                mm[addr] = mm[addr] + 1;
                o = putc(o, dst, mm[addr]);
            end
            12: o[8:1] = imm[7:0];
            13: o[0] = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic logic exp_valid();
        return (q_age.size() > 0) && (q_age[0] >= 2);
    endfunction

    task automatic chk(input string nm, input logic [PL-1:0] a, input logic [PL-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, a, e);
        end
    endtask

    task automatic compare();
        chk("valid", phv_out_valid, exp_valid());
        if (exp_valid()) chk("phv", phv_out, q_phv[0]);
    endtask

    task automatic cycle(input logic v, input logic [AL-1:0] a, input logic [PL-1:0] p, input logic rdy);
        logic en_m;
        @(negedge axis_clk);
        compare();
        action_in_valid = v;
        action_in       = a;
        phv_in          = p;
        ready_in        = rdy;
        #1;
        en_m = !exp_valid() || rdy;
        chk("ready_out", ready_out, en_m);
        if (en_m) begin
            if (exp_valid()) begin
                void'(q_phv.pop_front());
                void'(q_age.pop_front());
            end
            for (int i = 0; i < q_age.size(); i++) q_age[i]++;
            if (v) begin
                q_phv.push_back(model(a, p));
                q_age.push_back(1);
            end
        end
    endtask

    task automatic send(input int op, input int dst, input int src1, input logic [15:0] imm, input logic [PL-1:0] p);
        cycle(1'b1, act(op, dst, src1, imm), p, 1'b1);
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge axis_clk);
        aresetn = 1'b0;
        action_in_valid = 1'b0;
        #1;
        chk("rst_valid", phv_out_valid, 0);
        chk("rst_phv", phv_out, 0);
        q_phv.delete();
        q_age.delete();
        for (int i = 0; i < DEP; i++) mm[i] = '0;
        @(negedge axis_clk);
        aresetn = 1'b1;
    endtask

    initial begin
        logic [PL-1:0] p;
        logic [PL-1:0] p2;
        aresetn = 1'b0;
        action_in = '0;
        action_in_valid = 1'b0;
        phv_in = '0;
        ready_in = 1'b0;
        for (int i = 0; i < DEP; i++) mm[i] = '0;
        repeat (3) @(negedge axis_clk);
        aresetn = 1'b1;
        #1;
        chk("reset_valid", phv_out_valid, 0);
        chk("reset_phv", phv_out, 0);
        chk("reset_ready", ready_out, 1);

        // add C0 = C0 + C1
        p = putc(putc(rand_phv(), 0, 32'd5), 1, 32'd7);
        send(1, 0, 0, 16'h0001, p);
        idle(); idle();
        chk("add_valid", phv_out_valid, 1);
        chk("add_c0", getc(phv_out, 0), 32'd12);
        chk("add_c1", getc(phv_out, 1), 32'd7);

        // addi wraps modulo 2^32
        p = putc(rand_phv(), 0, 32'hFFFF_FFFF);
        send(3, 0, 0, 16'h0003, p);
        idle(); idle();
        chk("addi_wrap", getc(phv_out, 0), 32'h0000_0002);

        // store then load on consecutive cycles
        p  = putc(rand_phv(), 2, 32'h0000_ABCD);
        p2 = rand_phv();
        send(6, 0, 2, 16'h0004, p);
        send(7, 3, 0, 16'h0004, p2);
        idle(); idle();
        chk("fwd_load", getc(phv_out, 3), 32'h0000_ABCD);

        // loadd chain from cleared memory
        do_reset();
        send(8, 0, 0, 16'h0007, rand_phv());
        send(8, 0, 0, 16'h0007, rand_phv());
        send(8, 0, 0, 16'h0007, rand_phv());
        chk("loadd1", getc(phv_out, 0), 32'd1);
        send(7, 0, 0, 16'h0007, rand_phv());
        chk("loadd2", getc(phv_out, 0), 32'd2);
        idle();
        chk("loadd3", getc(phv_out, 0), 32'd3);
        idle();
        chk("load_after_loadd", getc(phv_out, 0), 32'd3);

        // backpressure: stalled input store must be ignored
        send(5, 0, 0, 16'h0011, rand_phv());
        send(5, 1, 0, 16'h0022, rand_phv());
        for (int i = 0; i < 4; i++)
            cycle(1'b1, act(6, 0, 2, 16'd20), putc(rand_phv(), 2, 32'hDEAD), 1'b0);
        chk("stall_ready", ready_out, 0);
        chk("stall_hold", getc(phv_out, 0), 32'h11);
        idle(); idle();
        chk("stall_second", getc(phv_out, 1), 32'h22);
        send(7, 0, 0, 16'd20, rand_phv());
        idle(); idle();
        chk("stall_no_write", getc(phv_out, 0), 32'd0);

        // metadata actions and out-of-range index
        send(12, 0, 0, 16'h0005, rand_phv());
        idle(); idle();
        chk("redirect", phv_out[8:1], 8'h05);
        p = rand_phv();
        p[0] = 1'b0;
        send(13, 0, 0, 16'h0000, p);
        idle(); idle();
        chk("discard", phv_out[0], 1'b1);
        p = rand_phv();
        send(1, 0, 9, 16'h0001, p);
        idle(); idle();
        chk("bad_index", phv_out, p);

        // reset with actions in flight
        send(8, 0, 0, 16'h0007, rand_phv());
        send(8, 0, 0, 16'h0007, rand_phv());
        do_reset();
        send(7, 0, 0, 16'h0007, rand_phv());
        idle(); idle();
        chk("mem_cleared", getc(phv_out, 0), 32'd0);

        // randomised traffic
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] imm;
            logic v, rdy;
            if ($urandom_range(0, 599) == 0) do_reset();
            imm = 16'($urandom);
            if ($urandom_range(0, 1) == 0) imm[4:0] = 5'($urandom_range(0, 3));
            v   = $urandom_range(0, 3) != 0;
            rdy = $urandom_range(0, 3) != 0;
            cycle(v, act($urandom_range(0, 15), $urandom_range(0, 9), $urandom_range(0, 9), imm),
                  rand_phv(), rdy);
        end
        for (int n = 0; n < 4; n++) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/action_engine_pipe.md
Name: action_engine_pipe

Overview:
Parametrised successor of the per-stage action engine. It applies one decoded action to a PHV and produces the modified PHV two cycles later. It generalises container width and count, immediate width and stateful memory depth. It adds valid/ready backpressure and a stateful ALU (store/load/load-increment) with read-after-write forwarding. It sits between the lookup engine and the next pipeline stage.

Parameters:
STAGE, 0, stage index; informational only, no behavioural effect.
CONT_W, 32, container width in bits.
NUM_CONT, 8, number of containers in the PHV.
IDX_W, 3, container index width; must satisfy 2^IDX_W >= NUM_CONT.
IMM_W, 16, immediate width.
MEM_DEPTH, 32, number of stateful memory words, each CONT_W bits wide.
ADDR_W, 5, log2(MEM_DEPTH).
MD_W, 256, metadata width; minimum 9.
PHV_LEN, NUM_CONT*CONT_W+MD_W, derived; do not override.
ACTION_LEN, 4+2*IDX_W+IMM_W, derived; do not override.

Ports:
axis_clk  in  1  clock.
aresetn  in  1  asynchronous active-low reset.
action_in  in  ACTION_LEN  {op[3:0], dst, src1, imm}, most significant field first.
action_in_valid  in  1  qualifies both action_in and phv_in.
phv_in  in  PHV_LEN  container k occupies bits [PHV_LEN-1-k*CONT_W -: CONT_W]; metadata occupies [MD_W-1:0].
ready_out  out  1  engine can accept an input this cycle.
phv_out  out  PHV_LEN  modified PHV.
phv_out_valid  out  1  phv_out holds valid data.
ready_in  in  1  next stage accepts phv_out.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - phv_out = 0, phv_out_valid = 0, stage-1 valid = 0.
  - All memory words cleared to 0.
  - In-flight actions are dropped.
  - ready_out = 1 once reset deasserts.
- Pipeline enable: en = !phv_out_valid || ready_in. ready_out = en, combinational.
- Acceptance: an input is accepted on an edge where action_in_valid && en.
- Stall: while en = 0, both stages and the memory hold their state. Inputs are ignored, no memory write occurs, and phv_out stays stable.
- Stage 1, on an enabled edge:
  - Registers the action, the PHV and the valid bit.
  - Reads mem[imm[ADDR_W-1:0]] synchronously.
  - Forwarding: if stage 2 writes the same address on the same edge, stage 1 captures the write data instead of the stale word.
- Stage 2, on an enabled edge: executes the action, registers phv_out, and drives phv_out_valid = stage-1 valid.
- Latency: exactly 2 enabled edges from acceptance to phv_out_valid. Throughput is 1 per cycle with no bubbles.
- Opcodes (C = containers; all arithmetic modulo 2^CONT_W; imm zero-extended to CONT_W):
  - 0000 nop.
  - 0001 add: C[dst] = C[src1] + C[imm[IDX_W-1:0]].
  - 0010 sub: C[dst] = C[src1] - C[imm[IDX_W-1:0]].
  - 0011 addi: C[dst] = C[src1] + imm.
  - 0100 subi: C[dst] = C[src1] - imm.
  - 0101 set: C[dst] = imm.
  - 0110 store: mem[addr] = C[src1]; PHV unchanged.
  - 0111 load: C[dst] = mem[addr].
  - 1000 loadd: C[dst] = mem[addr] + 1, and mem[addr] = mem[addr] + 1 (single read-modify-write).
  - 1100 redirect: md[8:1] = imm[7:0].
  - 1101 discard: md[0] = 1.
  - Any other opcode is treated as nop.
- Addressing: addr = imm[ADDR_W-1:0]; upper immediate bits are ignored for addressing.
- Index range: any dst, src1 or src2 index >= NUM_CONT turns the action into a nop. The PHV passes through unchanged and there is no memory write.
- Memory write timing: the write occurs only on the enabled edge at which the action leaves stage 2.
- Pass-through: containers and metadata bits that the action does not touch pass through unchanged.
- Idle inputs: when action_in_valid = 0, action_in and phv_in are don't-care.

Test Plan:
- Reset, then add dst=0, src1=0, src2=1 with C0=5, C1=7 -> 2 cycles later phv_out_valid=1, C0=12, all other bits unchanged.
- addi dst=0, src1=0, imm=3 with C0=0xFFFFFFFF -> C0=0x00000002 (wrap).
- Back-to-back store addr=4 (C2=0xABCD), then load dst=3 addr=4 on the next cycle -> second output has C3=0xABCD (forwarding path).
- Three consecutive loadd dst=0 addr=7 from reset -> outputs C0=1, 2, 3; a following load of addr 7 returns 3.
- Accept two PHVs, hold ready_in=0 for 4 cycles -> phv_out stable, ready_out=0, no memory change; release -> both emerge in order on consecutive cycles.
- redirect imm=0x05 -> md[8:1]=5. discard -> md[0]=1. add with src1=9 (NUM_CONT=8) -> PHV unchanged. Assert aresetn mid-stream -> phv_out_valid=0 immediately and memory reads back 0.
